// File: rtl/cpu_pkg.sv
// Shared CPU types: opcodes, core id, and the fetch-stage state and packet
// definitions used by the front end.
package cpu_pkg;

  typedef logic [7:0] core_id_t;

  typedef enum logic [7:0] {
    OP_NOP        = 8'h00,
    OP_JMP        = 8'h10,
    OP_JCC        = 8'h11,
    OP_ALU        = 8'h12,
    OP_RESTORE_PC = 8'h20,
    OP_HALT       = 8'hFF
  } opcode_e;

  typedef enum logic [1:0] {
    FETCH    = 2'd0,
    WAIT_RSP = 2'd1,
    SEND     = 2'd2,
    HALTED   = 2'd3
  } fetch_state_e;

  localparam logic [63:0] FETCH_PC_INCREMENT = 64'd4;

  // Widest lane mask a core may be built with; narrower masks are zero-extended.
  localparam int unsigned LANE_MASK_W = 32;

  typedef struct packed {
    logic [63:0]            pc;
    logic [31:0]            insn;
    logic [LANE_MASK_W-1:0] exec_mask;
  } fetch_packet_t;

endpackage

// File: rtl/fetch_packet_reg.sv
// Single-entry packet holding register between fetch and decode with a
// busy/recv handshake; a flush drops the pending packet.
module fetch_packet_reg
  import cpu_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic          flush_i,
  input  logic          recv_i,
  input  fetch_packet_t pkt_i,
  output logic          busy_o,
  output fetch_packet_t pkt_o
);

  logic          busy_q, busy_d;
  fetch_packet_t pkt_q, pkt_d;

  always_comb begin
    busy_d = busy_q;
    pkt_d  = pkt_q;
    if (flush_i) begin
      busy_d = 1'b0;
    end else if (load_i) begin
      busy_d = 1'b1;
      pkt_d  = pkt_i;
    end else if (recv_i && busy_q) begin
      busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      pkt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      pkt_q  <= pkt_d;
    end
  end

  assign busy_o = busy_q;
  assign pkt_o  = pkt_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: one outstanding memory read at a time, single packet
// handed to decode, PC redirect with stale-response dropping, and halt.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int unsigned CORE_ID     = 0,
  parameter logic [63:0] RESET_PC    = 64'h0,
  parameter int unsigned EXEC_MASK_W = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   mem_req_valid,
  output logic [63:0]            mem_req_addr,
  input  logic                   mem_req_ready,
  input  logic                   mem_rsp_valid,
  input  logic [31:0]            mem_rsp_data,
  output logic                   dec_busy,
  output logic [63:0]            dec_pc,
  output logic [31:0]            dec_insn,
  output logic [EXEC_MASK_W-1:0] dec_exec_mask,
  input  logic                   dec_recv,
  input  logic                   redirect_valid,
  input  logic [63:0]            redirect_pc,
  input  logic [EXEC_MASK_W-1:0] redirect_mask,
  input  logic                   halt
);

  fetch_state_e           state_q, state_d;
  logic [63:0]            pc_q, pc_d;
  logic [EXEC_MASK_W-1:0] mask_q, mask_d;
  logic                   drop_q, drop_d;
  logic                   redirect_take, req_fire, rsp_accept, abandon;
  fetch_packet_t          pkt_in, pkt_out;

  assign redirect_take = redirect_valid && !halt && (state_q != HALTED);
  assign req_fire      = mem_req_valid && mem_req_ready;
  assign rsp_accept    = (state_q == WAIT_RSP) && mem_rsp_valid && !redirect_take && !halt;
  // A request is still owed a response if it is in flight and not returning now.
  assign abandon       = ((state_q == WAIT_RSP) && !mem_rsp_valid) || req_fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (halt) begin
      state_d = HALTED;
    end else if (redirect_take) begin
      state_d = FETCH;
    end else begin
      case (state_q)
        FETCH:    if (req_fire)      state_d = WAIT_RSP;
        WAIT_RSP: if (mem_rsp_valid) state_d = SEND;
        SEND:     if (dec_recv)      state_d = FETCH;
        default:                     state_d = HALTED;
      endcase
    end
  end

  always_comb begin
    mem_req_valid = rst_n && (state_q == FETCH) && !drop_q;
    mem_req_addr  = pc_q;
    pkt_in        = '{pc: pc_q, insn: mem_rsp_data, exec_mask: LANE_MASK_W'(mask_q)};
  end

  always_comb begin
    pc_d   = pc_q;
    mask_d = mask_q;
    drop_d = drop_q;
    if (drop_q && mem_rsp_valid) drop_d = 1'b0;
    if ((halt || redirect_take) && abandon) drop_d = 1'b1;
    if (redirect_take) begin
      pc_d   = redirect_pc;
      mask_d = redirect_mask;
    end else if (rsp_accept) begin
      pc_d = pc_q + FETCH_PC_INCREMENT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= RESET_PC;
      mask_q <= '1;
      drop_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      mask_q <= mask_d;
      drop_q <= drop_d;
    end
  end

  fetch_packet_reg u_pkt (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (rsp_accept),
    .flush_i (halt || redirect_take),
    .recv_i  (dec_recv),
    .pkt_i   (pkt_in),
    .busy_o  (dec_busy),
    .pkt_o   (pkt_out)
  );

  assign dec_pc        = pkt_out.pc;
  assign dec_insn      = pkt_out.insn;
  assign dec_exec_mask = EXEC_MASK_W'(pkt_out.exec_mask);

`ifndef SYNTHESIS
  assert property (@(posedge clk) disable iff (!rst_n)
                   !(mem_rsp_valid && (state_q != WAIT_RSP) && !drop_q))
    else $error("fetch_stage core %0d: unsolicited mem_rsp_valid", CORE_ID);

  always_ff @(posedge clk) begin
    if (rst_n && rsp_accept)
      $info("FETCH core=%0d pc=%h insn=%h", CORE_ID, pc_q, mem_rsp_data);
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: transaction-level memory/PC model feeds an
// expected-packet queue that a negedge monitor checks against the DUT.
module tb_fetch_stage;

  localparam logic [63:0] RESET_PC = 64'h0;
  localparam int MW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          mem_req_valid;
  logic [63:0]   mem_req_addr;
  logic          mem_req_ready = 1'b0;
  logic          mem_rsp_valid = 1'b0;
  logic [31:0]   mem_rsp_data = '0;
  logic          dec_busy;
  logic [63:0]   dec_pc;
  logic [31:0]   dec_insn;
  logic [MW-1:0] dec_exec_mask;
  logic          dec_recv = 1'b0;
  logic          redirect_valid = 1'b0;
  logic [63:0]   redirect_pc = '0;
  logic [MW-1:0] redirect_mask = '0;
  logic          halt = 1'b0;

  always #5 clk = ~clk;

  fetch_stage #(.CORE_ID(3), .RESET_PC(RESET_PC), .EXEC_MASK_W(MW)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .dec_busy(dec_busy), .dec_pc(dec_pc), .dec_insn(dec_insn), .dec_exec_mask(dec_exec_mask),
    .dec_recv(dec_recv), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_mask(redirect_mask), .halt(halt)
  );

  typedef struct {
    logic [63:0]   pc;
    logic [31:0]   insn;
    logic [MW-1:0] mask;
  } pkt_t;

  pkt_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   n_pkts = 0;
  logic mon_en = 1'b0;
  logic exp_valid = 1'b0;
  logic [63:0] exp_addr = '0;

  // Reference model state: architectural PC/mask, halted, and the memory's
  // single in-flight read (stale once a redirect/halt overtakes it).
  logic [63:0]   m_pc;
  logic [MW-1:0] m_mask;
  logic          m_halted, m_inflight, m_stale;
  int            m_cnt;
  int            lat_force = -1;
  logic          data_force_en = 1'b0;
  logic [31:0]   data_force = '0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      chk("req_valid", mem_req_valid, exp_valid);
      if (mem_req_valid) chk("req_addr", mem_req_addr, exp_addr);
      chk("dec_busy", dec_busy, exp_q.size() != 0);
      if (dec_busy && exp_q.size() != 0) begin
        chk("dec_pc", dec_pc, exp_q[0].pc);
        chk("dec_insn", dec_insn, exp_q[0].insn);
        chk("dec_mask", dec_exec_mask, exp_q[0].mask);
        if (dec_recv && !redirect_valid && !halt) begin
          void'(exp_q.pop_front());
          n_pkts++;
        end
      end
    end
  end

  task automatic cycle(input logic rdy, input logic recv, input logic redir,
                       input logic [63:0] rpc, input logic [MW-1:0] rmask, input logic hlt);
    logic rsp, accept, push, flush;
    logic [31:0] data;
    pkt_t p;
    p = '{64'h0, 32'h0, '0};
    rsp  = m_inflight && (m_cnt == 0);
    data = data_force_en ? data_force : $urandom;
    exp_valid = !m_inflight && (exp_q.size() == 0) && !m_halted;
    exp_addr  = m_pc;
    accept = exp_valid && rdy;
    mem_req_ready  = rdy;
    mem_rsp_valid  = rsp;
    mem_rsp_data   = rsp ? data : $urandom;
    dec_recv       = recv;
    redirect_valid = redir;
    redirect_pc    = rpc;
    redirect_mask  = rmask;
    halt           = hlt;
    push = 1'b0;
    flush = 1'b0;
    if (rsp) m_inflight = 1'b0;
    else if (m_inflight) m_cnt--;
    if (accept) begin
      m_inflight = 1'b1;
      m_stale = 1'b0;
      m_cnt = (lat_force >= 0) ? lat_force : int'($urandom_range(0, 3));
    end
    if (hlt || (redir && !m_halted)) begin
      flush = 1'b1;
      if (m_inflight) m_stale = 1'b1;
      if (hlt) m_halted = 1'b1;
      else begin
        m_pc = rpc;
        m_mask = rmask;
      end
    end else if (rsp && !m_stale && !m_halted) begin
      push = 1'b1;
      p = '{m_pc, data, m_mask};
      m_pc = m_pc + 64'd4;
    end
    @(posedge clk);
    if (flush) exp_q.delete();
    if (push) exp_q.push_back(p);
    #1;
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    rst_n = 1'b0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0; dec_recv = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0; redirect_mask = '0; halt = 1'b0;
    exp_q.delete();
    m_pc = RESET_PC; m_mask = '1; m_halted = 1'b0;
    m_inflight = 1'b0; m_stale = 1'b0; m_cnt = 0;
    @(negedge clk);
    chk("rst_req_valid", mem_req_valid, 0);
    chk("rst_dec_busy", dec_busy, 0);
    chk("rst_dec_pc", dec_pc, 0);
    chk("rst_dec_insn", dec_insn, 0);
    chk("rst_dec_mask", dec_exec_mask, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_valid = 1'b1;
    exp_addr = RESET_PC;
    mon_en = 1'b1;
  endtask

  task automatic wait_pending(input string name, input int maxc);
    int i;
    i = 0;
    while (exp_q.size() == 0 && i < maxc) begin
      cycle(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
      i++;
    end
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL %s: no packet within %0d cycles", name, maxc);
    end
  endtask

  task automatic wait_inflight(input string name, input int maxc);
    int i;
    i = 0;
    while (!(m_inflight && !m_stale) && i < maxc) begin
      cycle(1'b1, 1'b1, 1'b0, '0, '0, 1'b0);
      i++;
    end
    n_vec++;
    if (!(m_inflight && !m_stale)) begin
      n_err++;
      $display("FAIL %s: no request accepted within %0d cycles", name, maxc);
    end
  endtask

  task automatic run_random(input int n, input logic allow_redir);
    logic [63:0] rpc;
    for (int i = 0; i < n; i++) begin
      rpc = {$urandom, $urandom & 32'hFFFF_FFFC};
      cycle(1'($urandom), 1'($urandom),
            allow_redir && ($urandom_range(0, 19) == 0), rpc, MW'($urandom), 1'b0);
    end
  endtask

  initial begin
    int pk;
    do_reset();

    // first fetch from reset: word 0x12 after two cycles, consumed at once
    lat_force = 1; data_force_en = 1'b1; data_force = 32'h0000_0012;
    repeat (6) cycle(1'b1, 1'b1, 1'b0, '0, '0, 1'b0);
    chk("first_pkt_count", n_pkts, 1);
    data_force_en = 1'b0; lat_force = -1;

    // decoder stall: packet held, no new request
    wait_pending("stall_wait", 20);
    repeat (5) cycle(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, '0, '0, 1'b0);

    // redirect while waiting on memory: stale response must be dropped
    lat_force = 3;
    wait_inflight("wait_rsp_wait", 20);
    pk = n_pkts;
    cycle(1'b0, 1'b1, 1'b1, 64'h100, 32'h0000_FFFF, 1'b0);
    lat_force = -1;
    wait_pending("after_redirect_wait", 30);
    chk("redir_pkt_pc", dec_pc, 64'h100);
    cycle(1'b1, 1'b1, 1'b0, '0, '0, 1'b0);
    chk("redir_pkt_count", n_pkts, pk + 1);

    // redirect and recv together while a PC 8 packet is pending
    cycle(1'b0, 1'b0, 1'b1, 64'h8, 32'hA5A5_5A5A, 1'b0);
    wait_pending("pc8_wait", 30);
    chk("pc8_pending", dec_pc, 64'h8);
    pk = n_pkts;
    cycle(1'b1, 1'b1, 1'b1, 64'h2000, 32'h1, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, '0, '0, 1'b0);
    chk("flush_no_delivery", n_pkts, pk);

    // 64-bit PC wrap
    cycle(1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, '1, 1'b0);
    wait_pending("wrap_wait", 30);
    repeat (3) cycle(1'b1, 1'b1, 1'b0, '0, '0, 1'b0);

    // randomized traffic with redirects
    pk = n_pkts;
    run_random(3000, 1'b1);
    chk("random_progress", (n_pkts - pk) > 100, 1);

    // halt while a packet is pending, then stay dead for 20 cycles
    wait_pending("halt_wait", 30);
    cycle(1'b1, 1'b0, 1'b0, '0, '0, 1'b1);
    run_random(20, 1'b1);

    // reset recovers fetch at RESET_PC
    do_reset();
    run_random(40, 1'b0);

    // reset in the middle of an outstanding request
    lat_force = 3;
    wait_inflight("midreset_wait", 20);
    lat_force = -1;
    do_reset();
    run_random(200, 1'b1);

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter CORE_ID, default 0, core identifier used in $display trace tags.
REQ-002 SHALL have parameter RESET_PC, default 64'h0, first fetch address after reset.
REQ-003 SHALL have parameter EXEC_MASK_W, default 32, width of the lane execution mask.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 mem_req_valid  output  1  instruction read request.
REQ-007 mem_req_addr  output  64  request address (PC).
REQ-008 mem_req_ready  input  1  memory accepts the request this cycle.
REQ-009 mem_rsp_valid  input  1  read data valid.
REQ-010 mem_rsp_data  input  32  instruction word.
REQ-011 dec_busy  output  1  packet pending for decode (decoder-side is_busy).
REQ-012 dec_pc  output  64  PC of the pending packet.
REQ-013 dec_insn  output  32  instruction word; opcode in bits [7:0].
REQ-014 dec_exec_mask  output  EXEC_MASK_W  lane mask of the pending packet.
REQ-015 dec_recv  input  1  decoder consumes the pending packet this cycle.
REQ-016 redirect_valid  input  1  execute-stage PC redirect (jump, cond jump, restore PC).
REQ-017 redirect_pc  input  64  new PC.
REQ-018 redirect_mask  input  EXEC_MASK_W  new lane mask.
REQ-019 halt  input  1  execute retired HALT.

Function
REQ-020 SHALL implement states FETCH, WAIT_RSP, SEND, HALTED.
REQ-021 FETCH: mem_req_valid=1, mem_req_addr=pc; on mem_req_ready -> WAIT_RSP.
REQ-022 WAIT_RSP: on mem_rsp_valid latch {pc, mem_rsp_data, mask} into the packet register, set dec_busy, pc<=pc+4 (64-bit wrap), -> SEND.
REQ-023 SEND: hold packet and dec_busy stable until dec_recv; on dec_recv clear dec_busy same edge and -> FETCH (no prefetch; at most one request outstanding).
REQ-024 dec_recv while dec_busy=0 SHALL be ignored.
REQ-025 redirect_valid in any non-HALTED state SHALL set pc<=redirect_pc, mask<=redirect_mask, clear dec_busy, -> FETCH next cycle.
REQ-026 Redirect in WAIT_RSP (or in FETCH with mem_req_ready=1 that cycle) SHALL set a drop flag; the next mem_rsp_valid is discarded and clears the flag; a new request SHALL NOT issue while the flag is set.
REQ-027 Redirect and dec_recv in the same cycle: redirect wins; packet is flushed.
REQ-028 halt SHALL -> HALTED from any state, clear dec_busy and mem_req_valid; HALTED exits only on reset.
REQ-029 halt and redirect_valid in the same cycle: halt wins.
REQ-030 mem_rsp_valid outside WAIT_RSP with drop flag clear SHALL be ignored and flag an assertion.
REQ-031 Per accepted packet SHALL $display "FETCH", CORE_ID, PC, insn.

Reset
REQ-032 On rst_n=0: state=FETCH, pc=RESET_PC, mask=all ones, dec_busy=0, mem_req_valid=0, dec_pc=0, dec_insn=0, dec_exec_mask=0, drop flag=0.
REQ-033 Reset mid-transaction SHALL abandon the outstanding request; first cycle after release SHALL present mem_req_valid=1 with mem_req_addr=RESET_PC.

Structure
REQ-034 FetchState enum, FETCH_PC_INCREMENT=4, and the fetch packet struct {PC, insn, exec_mask} SHALL live in the shared CPU package beside Opcode and CoreID.
REQ-035 The packet register with busy/recv handshake SHALL be a sub-module fetch_packet_reg; FSM, PC and drop logic stay in fetch_stage.

Verification
REQ-036 Reset, memory returns 32'h0000_0012 after 2 cycles, dec_recv immediately -> dec_pc=0, dec_insn=32'h12, next mem_req_addr=4.
REQ-037 Decoder stalls 5 cycles with dec_busy=1 -> packet unchanged, mem_req_valid=0 throughout.
REQ-038 Redirect to 64'h100 while WAIT_RSP -> stale response dropped, next request at 64'h100, no packet delivered with old PC.
REQ-039 Redirect and dec_recv same cycle while SEND at PC 8 -> dec_busy=0 next cycle, next mem_req_addr = redirect_pc.
REQ-040 halt while SEND -> dec_busy=0, mem_req_valid stays 0 for 20 cycles; rst_n low then high -> fetch resumes at RESET_PC.
REQ-041 pc=64'hFFFF_FFFF_FFFF_FFFC, one instruction accepted -> next mem_req_addr=0.
